univ_shift_reg: RTL and testbench

Parametrised universal shift register that generalises the single-bit serial-in/serial-out register to a WIDTH-bit register. It supports four modes: hold, shift right, shift left and parallel load, with independent serial inputs and outputs for each shift direction. A fill counter reports how many valid bits have been shifted in since the last clear or load. It sits between serial links and parallel datapaths as a SISO, SIPO, PISO or PIPO stage, selected by mode.

---
 rtl/univ_shift_reg.sv | 57 +++++
 tb/tb_univ_shift_reg.sv | 120 ++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit hold/shift-right/shift-left/load register with a saturating fill counter
module univ_shift_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int              CNT_W     = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic             data_in_r,
    input  logic             data_in_l,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] par_out,
    output logic             data_out_r,
    output logic             data_out_l,
    output logic [CNT_W-1:0] fill_cnt,
    output logic             full
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             shift;
    assign shift = mode == 2'b01 || mode == 2'b10;
    // next state: enable gates everything, clear beats mode, shifts saturate the counter
    always_comb begin
        q_d    = !en               ? q_q :
                 clear             ? RESET_VAL :
                 mode == 2'b01     ? {data_in_r, q_q[WIDTH-1:1]} :
                 mode == 2'b10     ? {q_q[WIDTH-2:0], data_in_l} :
                 mode == 2'b11     ? par_in : q_q;
        cnt_d  = !en               ? cnt_q :
                 clear             ? '0 :
                 mode == 2'b11     ? CNT_MAX :
                 (shift && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
        full_d = cnt_d == CNT_MAX;
    end
    // state registers; full is registered so every output comes straight from a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end
    assign par_out    = q_q;
    assign data_out_r = q_q[0];
    assign data_out_l = q_q[WIDTH-1];
    assign fill_cnt   = cnt_q;
    assign full       = full_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed and randomised checks of univ_shift_reg against an arithmetic model
module tb_univ_shift_reg;
    localparam int W = 8;
    logic         clk = 0, rst = 1, en = 0, clear = 0, data_in_r = 0, data_in_l = 0;
    logic [1:0]   mode = 0;
    logic [W-1:0] par_in = 0, par_out;
    logic         data_out_r, data_out_l, full;
    logic [3:0]   fill_cnt;
    int           n_chk = 0, n_fail = 0;
    int           m = 0, c = 0;

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode),
        .data_in_r(data_in_r), .data_in_l(data_in_l), .par_in(par_in),
        .par_out(par_out), .data_out_r(data_out_r), .data_out_l(data_out_l),
        .fill_cnt(fill_cnt), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("par_out", 32'(par_out), 32'(m));
        chk("data_out_r", 32'(data_out_r), 32'(m & 1));
        chk("data_out_l", 32'(data_out_l), 32'((m >> (W-1)) & 1));
        chk("fill_cnt", 32'(fill_cnt), 32'(c));
        chk("full", 32'(full), 32'(c == W));
    endtask

    task automatic cyc(input logic e, input logic cl, input logic [1:0] md,
                       input logic dr, input logic dl, input logic [W-1:0] p);
        en = e; clear = cl; mode = md; data_in_r = dr; data_in_l = dl; par_in = p;
        @(posedge clk);
        if (e) begin
            if (cl) begin
                m = 0; c = 0;
            end else if (md == 2'b01) begin
                m = (m >> 1) | (int'(dr) << (W-1)); c = (c + 1 > W) ? W : c + 1;
            end else if (md == 2'b10) begin
                m = ((m << 1) | int'(dl)) & ((1 << W) - 1); c = (c + 1 > W) ? W : c + 1;
            end else if (md == 2'b11) begin
                m = int'(p); c = W;
            end
        end
        #1 check_all();
    endtask

    task automatic async_rst();
        #2 rst = 1;
        #1 m = 0; c = 0;
        chk("rst_par_out", 32'(par_out), 32'h0);
        chk("rst_fill", 32'(fill_cnt), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        check_all();
        #2 rst = 0;
    endtask

    initial begin
        logic [15:0] stream;
        logic [W-1:0] pat;
        logic [7:0]  sipo;
        stream = 16'b0100_1101_0100_1101;
        repeat (2) @(posedge clk);
        #1 check_all();
        #3 rst = 0;
        cyc(1, 0, 2'b11, 0, 0, 8'hA5);
        cyc(1, 0, 2'b01, 1, 0, 8'h00);
        async_rst();
        cyc(1, 0, 2'b11, 0, 0, 8'hA5);
        chk("load_a5", 32'(par_out), 32'hA5);
        chk("load_a5_full", 32'(full), 32'h1);
        cyc(1, 1, 2'b00, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 2'b01, stream[i], 0, 8'h00);
            chk("siso_fill", 32'(fill_cnt), 32'((i + 1 > W) ? W : i + 1));
            if (i >= W - 1) chk("siso_out", 32'(data_out_r), 32'(stream[i-(W-1)]));
        end
        cyc(1, 1, 2'b00, 0, 0, 8'h00);
        sipo = 8'b1000_1011;
        for (int i = 0; i < W; i++) cyc(1, 0, 2'b01, sipo[i], 0, 8'h00);
        chk("sipo", 32'(par_out), 32'h8B);
        chk("sipo_full", 32'(full), 32'h1);
        pat = 8'h3C;
        cyc(1, 0, 2'b11, 0, 0, pat);
        chk("piso_0", 32'(data_out_r), 32'(pat[0]));
        for (int i = 1; i <= W; i++) begin
            cyc(1, 0, 2'b01, 0, 0, 8'h00);
            if (i < W) chk("piso_i", 32'(data_out_r), 32'(pat[i]));
        end
        chk("piso_end", 32'(par_out), 32'h00);
        cyc(1, 0, 2'b11, 0, 0, 8'h81);
        chk("left_outl0", 32'(data_out_l), 32'h1);
        cyc(1, 0, 2'b10, 0, 1, 8'h00);
        chk("left_1", 32'(par_out), 32'h03);
        chk("left_outl1", 32'(data_out_l), 32'h0);
        cyc(1, 0, 2'b10, 0, 1, 8'h00);
        chk("left_2", 32'(par_out), 32'h07);
        cyc(1, 0, 2'b10, 0, 1, 8'h00);
        chk("left_3", 32'(par_out), 32'h0F);
        cyc(0, 1, 2'b11, 0, 0, 8'hFF);
        chk("en0_hold", 32'(par_out), 32'h0F);
        cyc(1, 1, 2'b11, 0, 0, 8'hFF);
        chk("clr_wins", 32'(par_out), 32'h00);
        chk("clr_fill", 32'(fill_cnt), 32'h0);
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 15) == 0),
                2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            if (i == 100) async_rst();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
